// File: rtl/sfif_capture_wbs_if.sv
// Wishbone slave bus bundle for the sample-capture buffer.
// Signal names are from the slave's point of view (_i into the slave, _o out of it).
interface sfif_capture_wbs_if;
    logic [15:0] wb_dat_i;
    logic [17:0] wb_adr_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_dat_i, wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_dat_i, wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/sfif_capture_wbs.sv
// Multi-channel sample-capture buffer with one-shot / pre-post-trigger capture,
// a six-word CSR block and a windowed read-out of one channel at a time over a
// 16-bit Wishbone slave. Sample RAM is synchronous; window reads take one extra
// wait state so read data always lines up with ack.
module sfif_capture_wbs #(
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          DEPTH_LOG2   = 10,
    parameter int          NUM_CH       = 2,
    parameter logic [17:0] CSR_BASE     = 18'h01030,
    parameter logic [17:0] WIN_BASE     = 18'h02000
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    sfif_capture_wbs_if.slave              wb,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] smp_data,
    input  logic                           smp_valid,
    input  logic                           trig_i,
    output logic                           capt_busy,
    output logic                           capt_done
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam int          MEM_W     = NUM_CH * SAMPLE_WIDTH;
    localparam logic [17:0] WIN_BYTES = 18'(2 * DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PRE  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Capture control state
    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] trig_ptr_q, trig_ptr_d;
    logic [DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
    logic [DEPTH_LOG2-1:0] remain_q, remain_d;
    logic [3:0]            ch_sel_q, ch_sel_d;
    logic                  mode_q, mode_d;
    logic                  wrapped_q, wrapped_d;
    logic                  triggered_q, triggered_d;
    logic                  trig_prev_q, trig_prev_d;

    // Bus pipeline state
    logic                  ack_q, ack_d;
    logic                  pend_q, pend_d;
    logic [15:0]           dat_o_q, dat_o_d;
    logic                  win_zero_q, win_zero_d;
    logic [3:0]            rd_ch_q, rd_ch_d;

    // Sample memory: one wide word holds every channel for a given time slot
    logic [MEM_W-1:0]      mem_q [DEPTH];
    logic [MEM_W-1:0]      rd_word_q;

    // Address decode and strobes
    logic [17:0]           adr_w;
    logic [17:0]           csr_off;
    logic [17:0]           win_off;
    logic                  csr_hit;
    logic                  win_hit;
    logic [2:0]            csr_idx;
    logic [DEPTH_LOG2-1:0] win_idx;
    logic [DEPTH_LOG2-1:0] win_base;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  accept;
    logic                  csr_wr;
    logic                  win_rd;
    logic                  ctrl_wr;
    logic                  arm;
    logic                  abort;
    logic                  sw_trig;
    logic                  trig_edge;
    logic                  busy;
    logic                  smp_we;
    logic [15:0]           csr_rdata;
    logic [15:0]           chan_word;
    logic                  unused_bits;

    assign adr_w   = {wb.wb_adr_i[17:1], 1'b0};
    assign csr_off = adr_w - CSR_BASE;
    assign win_off = adr_w - WIN_BASE;
    assign csr_hit = (csr_off < 18'd12);
    assign win_hit = (win_off < WIN_BYTES);
    assign csr_idx = csr_off[3:1];
    assign win_idx = win_off[DEPTH_LOG2:1];

    // A new access is only taken when no ack or RAM read is in flight
    assign accept  = wb.wb_cyc_i && wb.wb_stb_i && !ack_q && !pend_q;
    assign csr_wr  = accept && wb.wb_we_i && csr_hit;
    assign win_rd  = accept && !wb.wb_we_i && win_hit;
    assign ctrl_wr = csr_wr && (csr_idx == 3'd0);
    assign arm     = ctrl_wr && wb.wb_dat_i[0];
    assign abort   = ctrl_wr && wb.wb_dat_i[2];
    assign sw_trig = ctrl_wr && wb.wb_dat_i[3];

    assign trig_edge = trig_i && !trig_prev_q;
    assign busy      = (state_q == ST_FILL) || (state_q == ST_PRE) || (state_q == ST_POST);
    assign smp_we    = smp_valid && busy;

    // Once the ring has wrapped in continuous mode the oldest sample sits at wr_ptr
    assign win_base = (mode_q && wrapped_q) ? wr_ptr_q : '0;
    assign rd_addr  = win_idx + win_base;

    assign capt_busy   = busy;
    assign capt_done   = (state_q == ST_DONE);
    assign wb.wb_dat_o = dat_o_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = 1'b0;
    assign wb.wb_rty_o = 1'b0;

    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[0], wb.wb_dat_i};

    // CSR read multiplexer
    always_comb begin
        csr_rdata = 16'h0000;
        case (csr_idx)
            3'd0:    csr_rdata = {14'h0, mode_q, 1'b0};
            3'd1:    csr_rdata = {11'h0, wrapped_q, triggered_q, state_q};
            3'd2:    csr_rdata = 16'(post_cnt_q);
            3'd3:    csr_rdata = 16'(trig_ptr_q);
            3'd4:    csr_rdata = 16'(wr_ptr_q);
            3'd5:    csr_rdata = {12'h0, ch_sel_q};
            default: csr_rdata = 16'h0000;
        endcase
    end

    // Channel select on the RAM output; unpopulated channels read as zero
    always_comb begin
        chan_word = 16'h0000;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_q == 4'(c)) begin
                chan_word = 16'(rd_word_q[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            end
        end
    end

    // Bus handshake: CSR/unmapped ack after one cycle, window reads after two
    always_comb begin
        ack_d      = 1'b0;
        pend_d     = pend_q;
        dat_o_d    = dat_o_q;
        win_zero_d = win_zero_q;
        rd_ch_d    = rd_ch_q;
        if (pend_q) begin
            pend_d = 1'b0;
            if (wb.wb_cyc_i) begin
                ack_d   = 1'b1;
                dat_o_d = win_zero_q ? 16'h0000 : chan_word;
            end
        end else if (accept) begin
            if (win_rd) begin
                pend_d     = 1'b1;
                win_zero_d = busy;
                rd_ch_d    = ch_sel_q;
            end else begin
                ack_d = 1'b1;
                if (!wb.wb_we_i) begin
                    dat_o_d = csr_hit ? csr_rdata : 16'h0000;
                end
            end
        end
    end

    // Capture FSM next state plus CSR register writes
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_ptr_d  = trig_ptr_q;
        post_cnt_d  = post_cnt_q;
        remain_d    = remain_q;
        ch_sel_d    = ch_sel_q;
        mode_d      = mode_q;
        wrapped_d   = wrapped_q;
        triggered_d = triggered_q;
        trig_prev_d = trig_i;

        if (ctrl_wr) begin
            mode_d = wb.wb_dat_i[1];
        end
        if (csr_wr && (csr_idx == 3'd2)) begin
            post_cnt_d = wb.wb_dat_i[DEPTH_LOG2-1:0];
        end
        if (csr_wr && (csr_idx == 3'd5)) begin
            ch_sel_d = wb.wb_dat_i[3:0];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d     = mode_d ? ST_PRE : ST_FILL;
                    wr_ptr_d    = '0;
                    wrapped_d   = 1'b0;
                    triggered_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (smp_valid) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (&wr_ptr_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PRE: begin
                if (smp_valid) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (&wr_ptr_q) begin
                        wrapped_d = 1'b1;
                    end
                end
                if (trig_edge || sw_trig) begin
                    trig_ptr_d  = wr_ptr_q;
                    triggered_d = 1'b1;
                    remain_d    = post_cnt_q;
                    state_d     = (post_cnt_q == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (smp_valid) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == DEPTH_LOG2'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Control and bus registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            post_cnt_q  <= '0;
            remain_q    <= '0;
            ch_sel_q    <= '0;
            mode_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            triggered_q <= 1'b0;
            trig_prev_q <= 1'b0;
            ack_q       <= 1'b0;
            pend_q      <= 1'b0;
            dat_o_q     <= '0;
            win_zero_q  <= 1'b0;
            rd_ch_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_ptr_q  <= trig_ptr_d;
            post_cnt_q  <= post_cnt_d;
            remain_q    <= remain_d;
            ch_sel_q    <= ch_sel_d;
            mode_q      <= mode_d;
            wrapped_q   <= wrapped_d;
            triggered_q <= triggered_d;
            trig_prev_q <= trig_prev_d;
            ack_q       <= ack_d;
            pend_q      <= pend_d;
            dat_o_q     <= dat_o_d;
            win_zero_q  <= win_zero_d;
            rd_ch_q     <= rd_ch_d;
        end
    end

    // Sample RAM: write port from the capture side, registered read port for the bus
    always_ff @(posedge wb_clk_i) begin
        if (smp_we) begin
            mem_q[wr_ptr_q] <= smp_data;
        end
        if (win_rd) begin
            rd_word_q <= mem_q[rd_addr];
        end
    end

endmodule

// File: tb/tb_sfif_capture_wbs.sv
// Directed bench for sfif_capture_wbs: one-shot fill, continuous capture with
// wrap, zero post count, abort, bus corner cases and asynchronous reset.
module tb_sfif_capture_wbs;

    localparam logic [17:0] CSR_BASE = 18'h01030;
    localparam logic [17:0] WIN_BASE = 18'h02000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] smp_data = '0;
    logic        smp_valid = 1'b0;
    logic        trig_i = 1'b0;
    logic        capt_busy;
    logic        capt_done;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    sfif_capture_wbs_if wb();

    sfif_capture_wbs dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb        (wb.slave),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .trig_i    (trig_i),
        .capt_busy (capt_busy),
        .capt_done (capt_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_read(input logic [17:0] adr, input logic [15:0] exp,
                           input int exp_lat, input string tag);
        int lat;
        logic [15:0] e;
        exp_q.push_back(exp);
        wb.wb_adr_i = adr;
        wb.wb_we_i  = 1'b0;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wb.wb_ack_o && lat < 8);
        e = exp_q.pop_front();
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_dat"}, {16'h0, wb.wb_dat_o}, {16'h0, e});
        @(posedge clk); #1;
        chk({tag, "_ack1"}, {31'h0, wb.wb_ack_o}, 32'h0);
    endtask

    task automatic wb_write(input logic [17:0] adr, input logic [15:0] dat, input string tag);
        int lat;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_we_i  = 1'b1;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wb.wb_ack_o && lat < 8);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        chk({tag, "_wlat"}, lat, 1);
        @(posedge clk); #1;
    endtask

    task automatic drive(input int start, input int count, input int trig_at,
                         input logic [15:0] ch1_xor);
        for (int i = 0; i < count; i++) begin
            int n;
            n = start + i;
            smp_data  = {16'(n) ^ ch1_xor, 16'(n)};
            smp_valid = 1'b1;
            trig_i    = (trig_at >= 0) && (n >= trig_at);
            @(posedge clk); #1;
        end
        smp_valid = 1'b0;
    endtask

    initial begin
        wb.wb_dat_i = '0;
        wb.wb_adr_i = '0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_sel_i = 2'b11;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, capt_busy}, 32'h0);
        chk("rst_done", {31'h0, capt_done}, 32'h0);
        chk("rst_ack",  {31'h0, wb.wb_ack_o}, 32'h0);
        chk("rst_dat",  {16'h0, wb.wb_dat_o}, 32'h0);
        chk("rst_err",  {30'h0, wb.wb_err_o, wb.wb_rty_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(CSR_BASE + 18'h2, 16'h0000, 1, "status_rst");
        wb_read(CSR_BASE + 18'h8, 16'h0000, 1, "wrptr_rst");

        // One-shot fill
        wb_write(CSR_BASE, 16'h0001, "arm_oneshot");
        wb_read(CSR_BASE + 18'h2, 16'h0001, 1, "status_fill");
        chk("busy_fill", {31'h0, capt_busy}, 32'h1);
        wb_read(WIN_BASE + 18'd10, 16'h0000, 2, "win_busy");
        drive(0, 10, -1, 16'hFFFF);
        wb_write(CSR_BASE, 16'h0001, "arm_busy");
        wb_read(CSR_BASE + 18'h2, 16'h0001, 1, "status_arm_busy");
        wb_read(CSR_BASE + 18'h8, 16'd10, 1, "wrptr_arm_busy");
        drive(10, 1014, -1, 16'hFFFF);
        chk("done_oneshot", {31'h0, capt_done}, 32'h1);
        chk("busy_oneshot", {31'h0, capt_busy}, 32'h0);
        wb_read(CSR_BASE + 18'h2, 16'h0004, 1, "status_oneshot");
        wb_read(CSR_BASE + 18'h8, 16'h0000, 1, "wrptr_oneshot");
        wb_write(CSR_BASE + 18'hA, 16'h0001, "chsel1");
        wb_read(WIN_BASE + 18'd10, 16'hFFFA, 2, "win_ch1_5");
        wb_read(CSR_BASE + 18'hA, 16'h0001, 1, "chsel_rd");
        wb_write(CSR_BASE + 18'hA, 16'h0000, "chsel0");
        wb_read(WIN_BASE + 18'd2046, 16'h03FF, 2, "win_ch0_1023");
        wb_write(WIN_BASE + 18'd6, 16'h1234, "win_wr");
        wb_read(WIN_BASE + 18'd6, 16'h0003, 2, "win_ch0_3");
        wb_write(CSR_BASE + 18'hA, 16'h0002, "chsel2");
        wb_read(WIN_BASE + 18'd10, 16'h0000, 2, "win_ch2");
        wb_write(CSR_BASE + 18'hA, 16'h0000, "chsel0b");
        wb_read(18'h01100, 16'h0000, 1, "unmapped");

        // Continuous capture with wrap
        wb_write(CSR_BASE + 18'h4, 16'd100, "postcnt100");
        wb_write(CSR_BASE, 16'h0003, "arm_cont");
        wb_read(CSR_BASE + 18'h2, 16'h0002, 1, "status_pre");
        drive(0, 1500, 1200, 16'h0000);
        trig_i = 1'b0;
        wb_read(CSR_BASE + 18'h2, 16'h001C, 1, "status_cont");
        wb_read(CSR_BASE + 18'h6, 16'd176, 1, "trigptr_cont");
        wb_read(CSR_BASE + 18'h8, 16'd277, 1, "wrptr_cont");
        wb_read(CSR_BASE + 18'h0, 16'h0002, 1, "ctrl_rd");
        wb_read(CSR_BASE + 18'h4, 16'd100, 1, "postcnt_rd");
        wb_read(WIN_BASE, 16'd277, 2, "win_oldest");
        wb_read(WIN_BASE + 18'd2046, 16'd1300, 2, "win_newest");

        // Zero post count with software trigger
        wb_write(CSR_BASE + 18'h4, 16'd0, "postcnt0");
        wb_write(CSR_BASE, 16'h0003, "arm_pc0");
        wb_read(CSR_BASE + 18'h2, 16'h0002, 1, "status_pc0_pre");
        drive(0, 5, -1, 16'h0000);
        wb_write(CSR_BASE, 16'h000A, "swtrig");
        chk("done_swtrig", {31'h0, capt_done}, 32'h1);
        wb_read(CSR_BASE + 18'h2, 16'h000C, 1, "status_swtrig");
        wb_read(CSR_BASE + 18'h8, 16'd5, 1, "wrptr_swtrig");
        wb_read(CSR_BASE + 18'h6, 16'd5, 1, "trigptr_swtrig");

        // Abort during POST after a wrapped pre-trigger phase
        wb_write(CSR_BASE + 18'h4, 16'd50, "postcnt50");
        wb_write(CSR_BASE, 16'h0003, "arm_abort");
        drive(0, 1030, 1029, 16'h0000);
        trig_i = 1'b0;
        wb_read(CSR_BASE + 18'h2, 16'h001B, 1, "status_post");
        wb_read(CSR_BASE + 18'h6, 16'd5, 1, "trigptr_post");
        wb_write(CSR_BASE, 16'h0006, "abort");
        chk("busy_abort", {31'h0, capt_busy}, 32'h0);
        chk("done_abort", {31'h0, capt_done}, 32'h0);
        wb_read(CSR_BASE + 18'h2, 16'h0018, 1, "status_abort");
        wb_write(CSR_BASE, 16'h0001, "rearm");
        wb_read(CSR_BASE + 18'h2, 16'h0001, 1, "status_rearm");
        wb_read(CSR_BASE + 18'h8, 16'h0000, 1, "wrptr_rearm");

        // Asynchronous reset in the middle of PRE, during an ack
        wb_write(CSR_BASE, 16'h0004, "abort2");
        wb_write(CSR_BASE, 16'h0003, "arm_pre_rst");
        drive(0, 4, -1, 16'h0000);
        wb.wb_adr_i = CSR_BASE + 18'h2;
        wb.wb_we_i  = 1'b0;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        chk("ack_pre_rst",  {31'h0, wb.wb_ack_o}, 32'h1);
        chk("busy_pre_rst", {31'h0, capt_busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ack_async_rst",  {31'h0, wb.wb_ack_o}, 32'h0);
        chk("busy_async_rst", {31'h0, capt_busy}, 32'h0);
        chk("done_async_rst", {31'h0, capt_done}, 32'h0);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(CSR_BASE + 18'h2, 16'h0000, 1, "status_after_rst");
        wb_read(CSR_BASE + 18'h0, 16'h0000, 1, "ctrl_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
